// File: rtl/conv_window_fetcher.sv
// Scan controller: walks every 5x5 output window of an image held in RAM, fetches one
// tile per window and hands it to the convolution stage over a valid/ready handshake.
module conv_window_fetcher #(
    localparam int K  = 5,
    parameter  int DW = 16,
    parameter  int AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW-1:0]     img_width,
    input  logic [AW-1:0]     img_height,
    input  logic [1:0]        stride,
    output logic              ram_enable,
    output logic              ram_write,
    output logic [AW-1:0]     ram_address,
    output logic [AW-1:0]     ram_offset,
    input  logic              ram_finish,
    input  logic [K*K*DW-1:0] ram_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [K*K*DW-1:0] win_data,
    output logic [AW-1:0]     win_row,
    output logic [AW-1:0]     win_col,
    output logic              win_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cfg_w;
    logic [1:0]    cfg_stride;
    logic [AW-1:0] out_w, out_h;
    logic [AW-1:0] row, col;
    logic [AW-1:0] row_base, addr;
    logic [AW-1:0] stride_ext, row_step;
    logic          cfg_bad, last_col, last_row;

    // Number of window positions along one axis; stride is limited to 1..3.
    function automatic logic [AW-1:0] out_count(input logic [AW-1:0] len,
                                                input logic [1:0]    s);
        logic [AW-1:0] span;
        span = len - AW'(K);
        case (s)
            2'd1:    out_count = span + AW'(1);
            2'd2:    out_count = (span >> 1) + AW'(1);
            default: out_count = span / AW'(3) + AW'(1);
        endcase
    endfunction

    assign cfg_bad    = (img_width < AW'(K)) || (img_height < AW'(K)) || (stride == 2'd0);
    assign stride_ext = AW'(cfg_stride);
    assign row_step   = stride_ext * cfg_w;
    assign last_col   = (col == out_w - AW'(1));
    assign last_row   = (row == out_h - AW'(1));

    assign ram_enable  = (state == FETCH);
    assign ram_write   = 1'b0;
    assign ram_address = addr;
    assign ram_offset  = cfg_w;
    assign win_valid   = (state == OUT);
    assign win_row     = row;
    assign win_col     = col;
    assign win_last    = win_valid && last_row && last_col;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = cfg_bad ? DONE : FETCH;
            FETCH:   if (ram_finish) state_nx = OUT;
            OUT:     if (win_ready) state_nx = win_last ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_w      <= '0;
            cfg_stride <= '0;
            out_w      <= '0;
            out_h      <= '0;
            row        <= '0;
            col        <= '0;
            row_base   <= '0;
            addr       <= '0;
            win_data   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cfg_w      <= img_width;
                    cfg_stride <= stride;
                    err        <= cfg_bad;
                    out_w      <= out_count(img_width, stride);
                    out_h      <= out_count(img_height, stride);
                    row        <= '0;
                    col        <= '0;
                    row_base   <= base_addr;
                    addr       <= base_addr;
                end
                FETCH: if (ram_finish) begin
                    win_data <= ram_data;
                end
                // Step to the next window only once the current tile has been taken.
                OUT: if (win_ready && !win_last) begin
                    if (!last_col) begin
                        col  <= col + AW'(1);
                        addr <= addr + stride_ext;
                    end else begin
                        col      <= '0;
                        row      <= row + AW'(1);
                        row_base <= row_base + row_step;
                        addr     <= row_base + row_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
